axis_packetizer: RTL and testbench

- Sits directly downstream of the stream FIFO. That FIFO drives tlast=0, so this block consumes its unframed beats and re-emits them as AXI-Stream packets.
- tlast is asserted on every cfg_pkt_len-th beat.
- tlast is also asserted on the most recent beat when the input goes idle for TIMEOUT_CYC cycles with a partial packet open.
- Uses one hold register plus one output register, giving full 1 beat/cycle throughput.

---
 rtl/axis_packetizer_if.sv | 12 +
 rtl/axis_packetizer.sv | 131 +++++++++++++
 tb/tb_axis_packetizer.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_packetizer_if.sv
// AXI-Stream bundle shared by the stream blocks; tdata width is set per instance.
interface axi_stream_if #(
  parameter int DATA_W = 32
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_packetizer.sv
// Frames the unframed beats from the stream FIFO into AXI-Stream packets,
// closing each on a fixed beat count or on an input idle timeout.
package params_pkg;
  localparam int AXIS_DATA_W = 32;
endpackage

module axis_packetizer
  import params_pkg::*;
#(
  parameter  int DATA_W      = AXIS_DATA_W,
  parameter  int MAX_PKT_LEN = 256,
  parameter  int TIMEOUT_CYC = 64,
  localparam int LEN_W       = $clog2(MAX_PKT_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  axi_stream_if.slave      s_axis,
  axi_stream_if.master     m_axis,
  input  logic [LEN_W-1:0] cfg_pkt_len,
  input  logic             cfg_timeout_en,
  output logic [15:0]      pkt_count,
  output logic [15:0]      timeout_count
);

  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  // Hold register: the newest accepted beat, kept until we know whether it is final.
  logic              hv, hl;
  logic [DATA_W-1:0] hdata;

  // Output register driving m_axis.
  logic              ov, ol;
  logic [DATA_W-1:0] od;

  logic [LEN_W-1:0]  beat_cnt, plen_q, eff_len, cur_len;
  logic [TMR_W-1:0]  timer;
  logic [15:0]       pkt_cnt_q, to_cnt_q;

  logic o_free, s_ready, accept, is_last, xfer, idle_wait, to_fire;

  assign o_free  = !ov || m_axis.tready;
  assign s_ready = reset_n && (!hv || o_free);
  assign accept  = s_axis.tvalid && s_ready;

  assign eff_len = (cfg_pkt_len == '0 || cfg_pkt_len > LEN_W'(MAX_PKT_LEN))
                   ? LEN_W'(MAX_PKT_LEN) : cfg_pkt_len;
  // The first beat of a packet decides its length; later beats use the latched copy.
  assign cur_len = (beat_cnt == '0) ? eff_len : plen_q;
  assign is_last = (beat_cnt + LEN_W'(1)) == cur_len;

  // A non-final held beat may only move on once its successor arrives.
  assign xfer      = hv && o_free && (hl || accept);
  assign idle_wait = hv && !hl && !accept;
  assign to_fire   = idle_wait && cfg_timeout_en && (timer == TMR_W'(TIMEOUT_CYC - 1));

  // NOTE: every state register uses non-blocking assignment so all blocks see pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hv <= 1'b0;
      hl <= 1'b0;
    end else if (accept) begin
      hv <= 1'b1;
      hl <= is_last;
    end else if (xfer) begin
      hv <= 1'b0;
      hl <= 1'b0;
    end else if (to_fire) begin
      hl <= 1'b1;
    end
  end

  // NOTE: hdata is pure datapath qualified by hv, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) hdata <= s_axis.tdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt <= '0;
      plen_q   <= '0;
    end else if (accept) begin
      if (beat_cnt == '0) plen_q <= eff_len;
      beat_cnt <= is_last ? '0 : beat_cnt + LEN_W'(1);
    end else if (to_fire) begin
      beat_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer <= '0;
    end else if (!idle_wait) begin
      timer <= '0;
    end else if (cfg_timeout_en) begin
      timer <= to_fire ? '0 : timer + TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ov <= 1'b0;
      ol <= 1'b0;
      od <= '0;
    end else if (xfer) begin
      ov <= 1'b1;
      ol <= hl;
      od <= hdata;
    end else if (ov && m_axis.tready) begin
      ov <= 1'b0;
      ol <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      if (ov && m_axis.tready && ol) pkt_cnt_q <= pkt_cnt_q + 16'd1;
      if (to_fire)                   to_cnt_q  <= to_cnt_q + 16'd1;
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = ov;
  assign m_axis.tlast  = ol;
  assign m_axis.tdata  = od;
  assign pkt_count     = pkt_cnt_q;
  assign timeout_count = to_cnt_q;

endmodule

// File: tb/tb_axis_packetizer.sv
// Directed bench for axis_packetizer: a cycle table plus scoreboarded stream sequences.
module tb_axis_packetizer;
  import params_pkg::*;

  localparam int DW   = AXIS_DATA_W;
  localparam int MAXL = 256;
  localparam int TO   = 8;
  localparam int LW   = $clog2(MAXL + 1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [LW-1:0] cfg_pkt_len;
  logic          cfg_timeout_en;
  logic [15:0]   pkt_count, timeout_count;

  axi_stream_if #(.DATA_W(DW)) s_if ();
  axi_stream_if #(.DATA_W(DW)) m_if ();

  always #5 clk = ~clk;

  axis_packetizer #(.DATA_W(DW), .MAX_PKT_LEN(MAXL), .TIMEOUT_CYC(TO)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .s_axis         (s_if),
    .m_axis         (m_if),
    .cfg_pkt_len    (cfg_pkt_len),
    .cfg_timeout_en (cfg_timeout_en),
    .pkt_count      (pkt_count),
    .timeout_count  (timeout_count)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
    logic          mr;
    logic          exp_sr;
    logic          exp_mv;
    logic [DW-1:0] exp_md;
    logic          exp_ml;
  } vec_t;

  beat_t got_q[$], exp_q[$];
  int    got_cyc[$], acc_cyc[$];
  int    cyc = 0;
  int    n_tests = 0, n_fail = 0;
  int    stab_err = 0, sready_err = 0;
  logic  prev_stall = 1'b0;
  beat_t prev_beat;
  bit    rnd_on = 1'b0;
  vec_t  tbl [15];

  // Output/handshake monitor, sampled at the edge before the DUT updates.
  always @(posedge clk) begin
    if (reset_n) begin
      if (prev_stall && !(m_if.tvalid && m_if.tdata == prev_beat.data && m_if.tlast == prev_beat.last))
        stab_err++;
      if (m_if.tvalid && m_if.tready) begin
        got_q.push_back({m_if.tdata, m_if.tlast});
        got_cyc.push_back(cyc);
      end
      if (s_if.tvalid && s_if.tready) acc_cyc.push_back(cyc);
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_beat  = {m_if.tdata, m_if.tlast};
    end else begin
      prev_stall = 1'b0;
    end
    cyc++;
  end

  // Input ready may only fall while the output register is stalled.
  always @(negedge clk) begin
    if (reset_n && !s_if.tready && !(m_if.tvalid && !m_if.tready)) sready_err++;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic clear_queues();
    got_q.delete();
    exp_q.delete();
    got_cyc.delete();
    acc_cyc.delete();
  endtask

  task automatic reset_dut();
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b1;
    @(posedge clk);
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    clear_queues();
  endtask

  task automatic send_beat(input logic [DW-1:0] d);
    int n;
    n = 0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    do begin
      @(posedge clk);
      n++;
    end while (!s_if.tready && n < 500);
    if (n >= 500) check("send_accept", 64'(s_if.tready), 64'(1));
    #1;
    s_if.tvalid = 1'b0;
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic last);
    exp_q.push_back({d, last});
  endtask

  task automatic wait_out(input int n);
    int k;
    k = 0;
    while (got_q.size() < n && k < 3000) begin
      @(posedge clk);
      k++;
    end
    #1;
  endtask

  task automatic check_stream(input string name);
    check($sformatf("%s_count", name), 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_beat%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [DW-1:0] d;

    s_if.tlast     = 1'b0;
    s_if.tvalid    = 1'b0;
    s_if.tdata     = '0;
    m_if.tready    = 1'b1;
    cfg_pkt_len    = LW'(4);
    cfg_timeout_en = 1'b0;

    // ---- reset values ----
    #3 reset_n = 1'b0;
    #10;
    check("rst_m_tvalid", 64'(m_if.tvalid), 64'(0));
    check("rst_m_tlast", 64'(m_if.tlast), 64'(0));
    check("rst_m_tdata", 64'(m_if.tdata), 64'(0));
    check("rst_pkt_count", 64'(pkt_count), 64'(0));
    check("rst_timeout_count", 64'(timeout_count), 64'(0));
    check("rst_s_tready", 64'(s_if.tready), 64'(0));

    // ---- cycle table, cfg_pkt_len=2, with output stalls ----
    //          v     d      mr    sr    mv    md     ml
    tbl[0]  = '{1'b1, 32'hA0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0};
    tbl[1]  = '{1'b1, 32'hA1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0};
    tbl[2]  = '{1'b1, 32'hA2, 1'b1, 1'b1, 1'b1, 32'hA0, 1'b0};
    tbl[3]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'hA1, 1'b1};
    tbl[4]  = '{1'b1, 32'hA3, 1'b0, 1'b0, 1'b1, 32'hA1, 1'b1};
    tbl[5]  = '{1'b1, 32'hA3, 1'b1, 1'b1, 1'b1, 32'hA1, 1'b1};
    tbl[6]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA2, 1'b0};
    tbl[7]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA3, 1'b1};
    tbl[8]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  1'b0};
    tbl[9]  = '{1'b1, 32'hB0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0};
    tbl[10] = '{1'b1, 32'hB1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0};
    tbl[11] = '{1'b1, 32'hB2, 1'b0, 1'b0, 1'b1, 32'hB0, 1'b0};
    tbl[12] = '{1'b1, 32'hB2, 1'b1, 1'b1, 1'b1, 32'hB0, 1'b0};
    tbl[13] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hB1, 1'b1};
    tbl[14] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  1'b0};
    cfg_pkt_len = LW'(2);
    reset_dut();
    for (int i = 0; i < 15; i++) begin
      s_if.tvalid = tbl[i].v;
      s_if.tdata  = tbl[i].d;
      m_if.tready = tbl[i].mr;
      @(negedge clk);
      check($sformatf("tbl%0d_s_tready", i), 64'(s_if.tready), 64'(tbl[i].exp_sr));
      check($sformatf("tbl%0d_m_tvalid", i), 64'(m_if.tvalid), 64'(tbl[i].exp_mv));
      if (tbl[i].exp_mv) begin
        check($sformatf("tbl%0d_m_tdata", i), 64'(m_if.tdata), 64'(tbl[i].exp_md));
        check($sformatf("tbl%0d_m_tlast", i), 64'(m_if.tlast), 64'(tbl[i].exp_ml));
      end
      @(posedge clk);
      #1;
    end
    check("tbl_pkt_count", 64'(pkt_count), 64'(3));

    // ---- framing: length 4, 12 back-to-back beats ----
    cfg_pkt_len = LW'(4);
    reset_dut();
    for (int i = 0; i < 12; i++) push_exp(DW'(i), (i % 4) == 3);
    for (int i = 0; i < 12; i++) send_beat(DW'(i));
    wait_out(12);
    if (got_cyc.size() == 12) check("frame_no_bubble", 64'(got_cyc[11] - got_cyc[0]), 64'(11));
    check("frame_pkt_count", 64'(pkt_count), 64'(3));
    check_stream("frame");

    // ---- idle timeout close ----
    cfg_pkt_len    = LW'(8);
    cfg_timeout_en = 1'b1;
    reset_dut();
    send_beat(32'hA);
    send_beat(32'hB);
    n = 0;
    while (!(m_if.tvalid && m_if.tlast) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("to_close_latency", 64'(n), 64'(TO + 1));
    check("to_count", 64'(timeout_count), 64'(1));
    push_exp(32'hA, 1'b0);
    push_exp(32'hB, 1'b1);
    for (int i = 0; i < 8; i++) push_exp(DW'(32'hC0 + i), i == 7);
    for (int i = 0; i < 8; i++) send_beat(DW'(32'hC0 + i));
    wait_out(10);
    if (got_cyc.size() >= 2 && acc_cyc.size() >= 2) begin
      check("to_a_after_b", 64'(got_cyc[0] - acc_cyc[1]), 64'(1));
      check("to_b_emit", 64'(got_cyc[1] - acc_cyc[1]), 64'(TO + 2));
    end
    check("to_count_after", 64'(timeout_count), 64'(1));
    check("to_pkt_count", 64'(pkt_count), 64'(2));
    check_stream("timeout");
    cfg_timeout_en = 1'b0;

    // ---- random backpressure, length 3 ----
    cfg_pkt_len = LW'(3);
    reset_dut();
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          m_if.tready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 300; i++) begin
      d = DW'($urandom);
      push_exp(d, (i % 3) == 2);
      if ($urandom_range(0, 9) < 3) begin
        @(posedge clk);
        #1;
      end
      send_beat(d);
    end
    wait_out(300);
    rnd_on = 1'b0;
    @(posedge clk);
    #2 m_if.tready = 1'b1;
    check("bp_pkt_count", 64'(pkt_count), 64'(100));
    check_stream("bp");

    // ---- length 1: every beat closes a packet ----
    cfg_pkt_len = LW'(1);
    reset_dut();
    for (int i = 0; i < 5; i++) push_exp(DW'(32'h100 + i), 1'b1);
    for (int i = 0; i < 5; i++) send_beat(DW'(32'h100 + i));
    wait_out(5);
    check("len1_pkt_count", 64'(pkt_count), 64'(5));
    check_stream("len1");

    // ---- length 0 means MAX_PKT_LEN ----
    cfg_pkt_len = LW'(0);
    reset_dut();
    for (int i = 0; i < 2 * MAXL; i++) push_exp(DW'(i), (i % MAXL) == MAXL - 1);
    for (int i = 0; i < 2 * MAXL; i++) send_beat(DW'(i));
    wait_out(2 * MAXL);
    check("len0_pkt_count", 64'(pkt_count), 64'(2));
    check_stream("len0");

    // ---- length change mid-packet takes effect on the next packet ----
    cfg_pkt_len = LW'(4);
    reset_dut();
    for (int i = 0; i < 6; i++) push_exp(DW'(32'h200 + i), i == 3 || i == 5);
    send_beat(32'h200);
    send_beat(32'h201);
    cfg_pkt_len = LW'(2);
    for (int i = 2; i < 6; i++) send_beat(DW'(32'h200 + i));
    wait_out(6);
    check_stream("lenchg");

    // ---- reset mid-operation with hold and output both occupied ----
    cfg_pkt_len = LW'(4);
    reset_dut();
    for (int i = 0; i < 4; i++) send_beat(DW'(i));
    wait_out(4);
    m_if.tready = 1'b0;
    send_beat(32'h10);
    send_beat(32'h11);
    check("mid_pre_tvalid", 64'(m_if.tvalid), 64'(1));
    check("mid_pre_pkt_count", 64'(pkt_count), 64'(1));
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_m_tvalid", 64'(m_if.tvalid), 64'(0));
    check("mid_rst_m_tlast", 64'(m_if.tlast), 64'(0));
    check("mid_rst_m_tdata", 64'(m_if.tdata), 64'(0));
    check("mid_rst_pkt_count", 64'(pkt_count), 64'(0));
    check("mid_rst_timeout_count", 64'(timeout_count), 64'(0));
    check("mid_rst_s_tready", 64'(s_if.tready), 64'(0));
    @(posedge clk);
    #2 reset_n = 1'b1;
    m_if.tready = 1'b1;
    @(posedge clk);
    #1;
    clear_queues();
    for (int i = 0; i < 4; i++) push_exp(DW'(32'h20 + i), i == 3);
    for (int i = 0; i < 4; i++) send_beat(DW'(32'h20 + i));
    wait_out(4);
    check("mid_after_pkt_count", 64'(pkt_count), 64'(1));
    check_stream("mid_after");

    // ---- timeout disabled holds a lone beat indefinitely ----
    cfg_pkt_len    = LW'(8);
    cfg_timeout_en = 1'b0;
    reset_dut();
    send_beat(32'h55);
    repeat (1000) @(posedge clk);
    #1;
    check("todis_no_output", 64'(got_q.size()), 64'(0));
    check("todis_m_tvalid", 64'(m_if.tvalid), 64'(0));
    check("todis_timeout_count", 64'(timeout_count), 64'(0));
    cfg_timeout_en = 1'b1;
    n = 0;
    while (!m_if.tvalid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("toen_latency", 64'(n), 64'(TO + 1));
    check("toen_tdata", 64'(m_if.tdata), 64'(32'h55));
    check("toen_tlast", 64'(m_if.tlast), 64'(1));
    check("toen_timeout_count", 64'(timeout_count), 64'(1));
    repeat (3) @(posedge clk);
    #1;

    check("stall_stability", 64'(stab_err), 64'(0));
    check("s_tready_drop", 64'(sready_err), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
